// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, sampled mid-bit.
// Frames that end in a low stop bit park in BREAK until the line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       ret,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          par_reg, par_next;
    logic [7:0]    data_reg, data_next;
    logic          rx_valid_reg, rx_valid_next;
    logic          parity_err_reg, parity_err_next;
    logic          frame_err_reg, frame_err_next;
    logic          sync1_reg, rx_s;
    logic          sample_tick;

    always_ff @(posedge clk or negedge ret) begin
        if (!ret) begin
            sync1_reg      <= 1'b1;
            rx_s           <= 1'b1;
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            data_reg       <= 8'h00;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            sync1_reg      <= rx;
            rx_s           <= sync1_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            par_reg        <= par_next;
            data_reg       <= data_next;
            rx_valid_reg   <= rx_valid_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // The start bit is sampled half a bit in; every later bit one full bit after that.
    assign sample_tick = (state_reg == START) ? (cnt_reg == HALF_M1) : (cnt_reg == FULL_M1);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + CW'(1);
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        par_next        = par_reg;
        data_next       = data_reg;
        rx_valid_next   = 1'b0;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;
        if (state_reg != IDLE && state_reg != BREAK && sample_tick)
            cnt_next = '0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                    bit_next   = '0;
                end
            end
            START: begin
                if (sample_tick)
                    state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (sample_tick) begin
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7)
                        state_next = PARITY;
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    par_next   = rx_s;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_tick) begin
                    data_next       = shift_reg;
                    parity_err_next = par_reg ^ (^shift_reg);
                    frame_err_next  = ~rx_s;
                    rx_valid_next   = 1'b1;
                    state_next      = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign data       = data_reg;
    assign rx_valid   = rx_valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 8: nominal, parity, framing/break,
// glitch, back-to-back and mid-frame reset scenarios.
module tb_uart_rx;
    localparam int C = 8;

    logic       clk = 1'b0;
    logic       ret = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       rx_valid, parity_err, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int pulse_count = 0;
    int last_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic last_pe = 1'b0;
    logic last_fe = 1'b0;
    int base_count;
    int c1;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .ret(ret), .rx(rx), .data(data), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder; cyc here equals the number of the edge that raised rx_valid.
    always @(negedge clk) begin
        if (rx_valid) begin
            pulse_count <= pulse_count + 1;
            last_cyc    <= cyc;
            last_data   <= data;
            last_pe     <= parity_err;
            last_fe     <= frame_err;
            $display("rx_valid pulse #%0d at edge %0d data=%02h parity_err=%0b frame_err=%0b",
                     pulse_count + 1, cyc, data, parity_err, frame_err);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Called at a negedge; t0 is the next posedge, where the first sync flop sees the start bit.
    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        rx = 1'b0;
        t0 = cyc + 1;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = p;
        repeat (C) @(negedge clk);
        rx = s;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        $display("sent frame data=%02h parity=%0b stop=%0b t0=%0d", b, p, s, t0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", int'(data), 8'h00);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_parity_err", int'(parity_err), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        ret = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal 0xA5: stop sample at t0+86, first edge seeing rx_valid is t0+87.
        send_frame(8'hA5, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("a5_pulses", pulse_count, 1);
        check("a5_data", int'(last_data), 8'hA5);
        check("a5_parity_err", int'(last_pe), 0);
        check("a5_frame_err", int'(last_fe), 0);
        check("a5_latency", last_cyc + 1 - t0, 87);
        check("a5_busy_after", int'(busy), 0);
        check("a5_rx_valid_low", int'(rx_valid), 0);
        check("a5_data_held", int'(data), 8'hA5);

        // 0x01 has odd weight, so a parity bit of 0 is wrong.
        send_frame(8'h01, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("par_pulses", pulse_count, 2);
        check("par_data", int'(last_data), 8'h01);
        check("par_parity_err", int'(last_pe), 1);
        check("par_frame_err", int'(last_fe), 0);

        // Framing error followed by a held-low break.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check("brk_pulses", pulse_count, 3);
        check("brk_data", int'(last_data), 8'h3C);
        check("brk_frame_err", int'(last_fe), 1);
        check("brk_parity_err", int'(last_pe), 0);
        check("brk_busy_low_line", int'(busy), 1);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("brk_busy_2_after_rise", int'(busy), 1);
        @(negedge clk);
        check("brk_busy_3_after_rise", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("brk_no_second_pulse", pulse_count, 3);

        // Two-cycle glitch: START samples rx_s high and returns to IDLE.
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_high", int'(busy), 1);
        repeat (6) @(negedge clk);
        check("glitch_busy_low", int'(busy), 0);
        repeat (4) @(negedge clk);
        check("glitch_no_pulse", pulse_count, 3);
        check("glitch_data_held", int'(data), 8'h3C);

        // Back-to-back frames with no idle gap.
        send_frame(8'h55, 1'b0, 1'b1);
        c1 = last_cyc;
        check("b2b_first_pulses", pulse_count, 4);
        check("b2b_first_data", int'(last_data), 8'h55);
        send_frame(8'hAA, 1'b0, 1'b1);
        check("b2b_mid_second_data", int'(data), 8'hAA);
        repeat (2) @(negedge clk);
        check("b2b_second_pulses", pulse_count, 5);
        check("b2b_second_data", int'(last_data), 8'hAA);
        check("b2b_spacing", last_cyc - c1, 88);

        // Reset during bit 4 of 0xFF aborts the frame.
        base_count = pulse_count;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        repeat (4 * C + 3) @(negedge clk);
        check("rst_busy_before", int'(busy), 1);
        ret = 1'b0;
        #1;
        check("rst_async_busy", int'(busy), 0);
        check("rst_async_data", int'(data), 8'h00);
        check("rst_async_rx_valid", int'(rx_valid), 0);
        repeat (3) @(negedge clk);
        ret = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_pulse", pulse_count, base_count);
        send_frame(8'h12, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("rst_after_pulses", pulse_count, base_count + 1);
        check("rst_after_data", int'(last_data), 8'h12);
        check("rst_after_parity_err", int'(last_pe), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8, clk cycles per bit; legal range even values >= 4.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 ret  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  serial line; asynchronous to clk; idle high.
REQ-005 data  output  8  last received byte.
REQ-006 rx_valid  output  1  one-cycle pulse: data, parity_err and frame_err updated.
REQ-007 parity_err  output  1  received parity bit differs from ^data of the same frame.
REQ-008 frame_err  output  1  stop bit sampled low.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 The frame format SHALL be: start 0, data[0]..data[7] (LSB first), even parity bit equal to ^data, stop 1, one bit per CLKS_PER_BIT cycles.
REQ-011 The rx input SHALL pass through a 2-flop synchronizer (both flops reset to 1); the FSM SHALL use only the second flop output (rx_s).
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE -> START SHALL occur on the first cycle rx_s is 0; bit counter and cycle counter cleared.
REQ-014 START SHALL wait CLKS_PER_BIT/2 cycles and sample rx_s once: 0 -> DATA; 1 -> IDLE (glitch rejected, no rx_valid).
REQ-015 Each subsequent bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-016 DATA SHALL shift sampled bits into data[7:0] LSB first; after the 8th sample -> PARITY.
REQ-017 PARITY SHALL sample one bit and store it; then -> STOP.
REQ-018 At the stop sample the block SHALL update data, parity_err = (parity ^ (^data)), frame_err = ~rx_s, and pulse rx_valid high for exactly the next cycle.
REQ-019 After the stop sample, the FSM SHALL go to IDLE if rx_s = 1, else to BREAK.
REQ-020 BREAK SHALL hold until rx_s = 1, then go to IDLE; no rx_valid is generated in BREAK.
REQ-021 data, parity_err, frame_err SHALL hold their values between rx_valid pulses; they SHALL not change mid-frame.
REQ-022 Latency: with t0 = the clk edge at which the first sync flop captures rx = 0, sample k (k = 0 start ... 10 stop) SHALL occur at edge t0 + 2 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT; rx_valid SHALL be high for the cycle after the stop-sample edge.
REQ-023 A new start bit SHALL be accepted on the cycle immediately after return to IDLE (back-to-back frames with no idle gap).
REQ-024 The counters SHALL be sized for CLKS_PER_BIT and SHALL not wrap within a bit period.

Reset
REQ-025 While ret = 0, the block SHALL force state IDLE, counters 0, sync flops 1, data 8'h00, rx_valid 0, parity_err 0, frame_err 0, busy 0, regardless of clk.
REQ-026 Reset asserted mid-frame SHALL abort the frame without an rx_valid pulse; after release, reception SHALL resume at the next falling edge of rx.

Verification (CLKS_PER_BIT = 8)
REQ-027 The bench SHALL cover a nominal frame: send 0xA5, parity 0, stop 1 -> one rx_valid pulse, data = 8'hA5, parity_err = 0, frame_err = 0, pulse at t0 + 2 + 4 + 80 + 1.
REQ-028 The bench SHALL cover a parity error: send 0x01 with parity bit 0 -> data = 8'h01, parity_err = 1, frame_err = 0.
REQ-029 The bench SHALL cover a framing error and break: send 0x3C with stop bit 0, then hold rx low for 40 cycles -> data = 8'h3C, frame_err = 1, busy high until 2 cycles after rx rises, and no second rx_valid pulse.
REQ-030 The bench SHALL cover glitch rejection: rx low for 2 cycles, then high -> busy pulses, no rx_valid, and FSM back in IDLE.
REQ-031 The bench SHALL cover back-to-back frames: send 0x55 then 0xAA with no idle gap -> two rx_valid pulses 88 cycles apart, with data 8'h55 then 8'hAA.
REQ-032 The bench SHALL cover reset mid-frame: assert ret = 0 during bit 4 of 0xFF, release, then send 0x12 -> no pulse for the aborted frame, one pulse with data = 8'h12.
